// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction-memory request/response plus the IF/ID handshake.
interface fetch_stage_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic        id_fault;

  modport master (
    output imem_req_valid, imem_addr, id_valid, id_instr, id_pc, id_pc_plus4, id_fault,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready
  );

  modport slave (
    input  imem_req_valid, imem_addr, id_valid, id_instr, id_pc, id_pc_plus4, id_fault,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready
  );
endinterface

// File: rtl/fetch_stage.sv
// RV32I fetch stage: PC owner, single-outstanding imem reads, IF/ID register with 1-entry skid.
// Optional macro FETCH_MISALIGN_CHK_EN: misaligned redirects emit a fault entry and halt fetch.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          redirect_valid,
  input  logic [31:0]   redirect_pc,
  fetch_stage_if.master bus
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] req_pc_p0;
  logic        skid_vld_p1;
  logic [31:0] skid_instr_p1;
  logic [31:0] skid_pc_p1;
  logic        out_vld_p1;
  logic [31:0] out_instr_p1;
  logic [31:0] out_pc_p1;
  logic [31:0] out_pc4_p1;

  logic        fetch_halt;
  logic        misalign;
  logic [31:0] redirect_tgt;
  logic        req_fire;
  logic        rsp_take;
  logic        out_free;
  logic        pop;

`ifdef FETCH_MISALIGN_CHK_EN
  logic halt_q;
  logic out_fault_p1;

  assign misalign     = (redirect_pc[1:0] != 2'b00);
  assign redirect_tgt = redirect_pc;
  assign fetch_halt   = halt_q;
  assign bus.id_fault = out_fault_p1;

  // Fault entry lives until popped; halt persists until the next aligned redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halt_q       <= 1'b0;
      out_fault_p1 <= 1'b0;
    end else if (redirect_valid) begin
      halt_q       <= misalign;
      out_fault_p1 <= misalign;
    end else if (pop) begin
      out_fault_p1 <= 1'b0;
    end
  end
`else
  assign misalign     = 1'b0;
  assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;
  assign fetch_halt   = 1'b0;
  assign bus.id_fault = 1'b0;
`endif

  assign bus.imem_req_valid = rst_n & (state_q == S_REQ) & ~skid_vld_p1
                              & ~redirect_valid & ~fetch_halt;
  assign bus.imem_addr      = pc_q;
  assign req_fire           = bus.imem_req_valid & bus.imem_req_ready;
  assign rsp_take           = (state_q == S_WAIT) & bus.imem_rsp_valid & ~redirect_valid;
  assign out_free           = ~out_vld_p1 | bus.id_ready;
  assign pop                = out_vld_p1 & bus.id_ready;

  assign bus.id_valid    = out_vld_p1;
  assign bus.id_instr    = out_instr_p1;
  assign bus.id_pc       = out_pc_p1;
  assign bus.id_pc_plus4 = out_pc4_p1;

  // ---- p0: request issue / p1: IF/ID output register and skid ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      skid_vld_p1  <= 1'b0;
      out_vld_p1   <= 1'b0;
      out_instr_p1 <= NOP_INSTR;
      out_pc_p1    <= 32'h0000_0000;
      out_pc4_p1   <= 32'h0000_0004;
    end else if (redirect_valid) begin
      pc_q         <= redirect_tgt;
      skid_vld_p1  <= 1'b0;
      out_vld_p1   <= misalign;
      out_instr_p1 <= NOP_INSTR;
      if (misalign) begin
        out_pc_p1  <= redirect_pc;
        out_pc4_p1 <= redirect_pc + 32'd4;
      end
      // Any fetch still in flight becomes stale unless its response lands now.
      case (state_q)
        S_WAIT, S_DROP: state_q <= bus.imem_rsp_valid ? S_REQ : S_DROP;
        default:        state_q <= S_REQ;
      endcase
    end else begin
      if (req_fire) begin
        pc_q    <= pc_q + 32'd4;
        state_q <= S_WAIT;
      end else if (state_q != S_REQ && bus.imem_rsp_valid) begin
        state_q <= S_REQ;
      end

      if (rsp_take && out_free) begin
        out_vld_p1   <= 1'b1;
        out_instr_p1 <= bus.imem_rsp_data;
        out_pc_p1    <= req_pc_p0;
        out_pc4_p1   <= req_pc_p0 + 32'd4;
      end else if (pop) begin
        if (skid_vld_p1) begin
          out_instr_p1 <= skid_instr_p1;
          out_pc_p1    <= skid_pc_p1;
          out_pc4_p1   <= skid_pc_p1 + 32'd4;
          skid_vld_p1  <= 1'b0;
        end else begin
          out_vld_p1   <= 1'b0;
          out_instr_p1 <= NOP_INSTR;
        end
      end

      if (rsp_take && !out_free) skid_vld_p1 <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) req_pc_p0 <= pc_q;
    if (rsp_take && !out_free) begin
      skid_instr_p1 <= bus.imem_rsp_data;
      skid_pc_p1    <= req_pc_p0;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed redirect/skid/wrap scenarios against a latency-programmable imem model.
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        fault;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;

  fetch_stage_if bus();

  fetch_stage dut (
    .clk(clk),
    .rst_n(rst_n),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .bus(bus)
  );

  always #5 clk = ~clk;

  ent_t        exp_q[$];
  int          total = 0;
  int          bad = 0;
  int          lat = 1;
  int          fire_cnt = 0;
  logic [31:0] last_fire_addr = 32'h0;
  int          acc_cnt = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  int          prev_acc_cyc = 0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  function automatic ent_t mk(input logic [31:0] pc);
    ent_t e;
    e.instr = memf(pc);
    e.pc    = pc;
    e.pc4   = pc + 32'd4;
    e.fault = 1'b0;
    return e;
  endfunction

  function automatic ent_t mkfault(input logic [31:0] pc);
    ent_t e;
    e.instr = NOP;
    e.pc    = pc;
    e.pc4   = pc + 32'd4;
    e.fault = 1'b1;
    return e;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Instruction memory: accepts every request, answers after lat cycles.
  initial begin
    int          cnt;
    logic        pend;
    logic [31:0] paddr;
    cnt = 0;
    pend = 1'b0;
    paddr = 32'h0;
    bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    forever begin
      @(negedge clk);
      #1;
      bus.imem_rsp_valid = 1'b0;
      if (!rst_n) begin
        pend = 1'b0;
        fire_cnt = 0;
      end else begin
        if (pend) begin
          if (cnt == 1) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = memf(paddr);
            pend = 1'b0;
          end else begin
            cnt--;
          end
        end
        if (bus.imem_req_valid && bus.imem_req_ready) begin
          pend = 1'b1;
          paddr = bus.imem_addr;
          cnt = lat;
          fire_cnt++;
          last_fire_addr = bus.imem_addr;
        end
      end
    end
  end

  // Monitor: every accepted IF/ID entry is popped from the scoreboard and compared.
  initial begin
    ent_t e;
    ent_t g;
    forever begin
      @(negedge clk);
      #3;
      if (!rst_n) begin
        acc_cnt = 0;
      end else if (bus.id_valid && bus.id_ready) begin
        acc_cnt++;
        prev_acc_cyc = acc_cyc;
        acc_cyc = cyc;
        g = {bus.id_instr, bus.id_pc, bus.id_pc_plus4, bus.id_fault};
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_entry: got pc=%h instr=%h, wanted no entry", g.pc, g.instr);
        end else begin
          e = exp_q.pop_front();
          if (g !== e) begin
            bad++;
            $display("FAIL entry: got instr=%h pc=%h pc4=%h fault=%b want instr=%h pc=%h pc4=%h fault=%b",
                     g.instr, g.pc, g.pc4, g.fault, e.instr, e.pc, e.pc4, e.fault);
          end
        end
      end else if (!bus.id_valid) begin
        total++;
        if (bus.id_instr !== NOP) begin
          bad++;
          $display("FAIL idle_instr: got %h want %h", bus.id_instr, NOP);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic do_reset(input int latency);
    @(negedge clk);
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    bus.id_ready = 1'b0;
    lat = latency;
    repeat (2) @(negedge clk);
    #2;
    chk("rst_id_valid", 32'(bus.id_valid), 32'd0);
    chk("rst_id_instr", bus.id_instr, NOP);
    chk("rst_id_pc", bus.id_pc, 32'h0);
    chk("rst_id_pc_plus4", bus.id_pc_plus4, 32'h4);
    chk("rst_id_fault", 32'(bus.id_fault), 32'd0);
    chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("rst_imem_addr", bus.imem_addr, 32'h0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_fire(input int n, input string name);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #2;
      if (fire_cnt >= n) return;
    end
    total++;
    bad++;
    $display("FAIL %s_timeout: got %0d requests want %0d", name, fire_cnt, n);
  endtask

  task automatic drain(input int n, input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      #4;
      if (acc_cnt >= n) done = 1'b1;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got %0d entries want %0d", name, acc_cnt, n);
    end
    @(negedge clk);
    bus.id_ready = 1'b0;
    chk({name, "_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    bit seen;
    bus.id_ready = 1'b0;

    // Straight-line fetch, 1-cycle memory, decode always ready.
    do_reset(1);
    bus.id_ready = 1'b1;
    exp_q.push_back(mk(32'h0));
    exp_q.push_back(mk(32'h4));
    exp_q.push_back(mk(32'h8));
    exp_q.push_back(mk(32'hC));
    drain(4, "t1");
    chk("t1_spacing", 32'(acc_cyc - prev_acc_cyc), 32'd2);

    // Decode stalls: second word parks in the skid and fetch stops.
    do_reset(1);
    exp_q.push_back(mk(32'h0));
    exp_q.push_back(mk(32'h4));
    exp_q.push_back(mk(32'h8));
    exp_q.push_back(mk(32'hC));
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      #2;
      if (bus.id_valid) seen = 1'b1;
    end
    chk("t2_first_valid", 32'(seen), 32'd1);
    repeat (10) @(negedge clk);
    #2;
    chk("t2_req_count", 32'(fire_cnt), 32'd2);
    chk("t2_req_blocked", 32'(bus.imem_req_valid), 32'd0);
    chk("t2_hold_pc", bus.id_pc, 32'h0);
    @(negedge clk);
    bus.id_ready = 1'b1;
    drain(4, "t2");

    // Redirect while the fetch of 0x8 is outstanding (3-cycle memory).
    do_reset(3);
    bus.id_ready = 1'b1;
    exp_q.push_back(mk(32'h0));
    exp_q.push_back(mk(32'h4));
    exp_q.push_back(mk(32'h100));
    exp_q.push_back(mk(32'h104));
    wait_fire(3, "t3_fetch8");
    chk("t3_addr8", last_fire_addr, 32'h8);
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    @(negedge clk);
    redirect_valid = 1'b0;
    wait_fire(4, "t3_target");
    chk("t3_target_addr", last_fire_addr, 32'h100);
    drain(4, "t3");

    // Redirect in the same cycle as the response of 0x4.
    do_reset(2);
    bus.id_ready = 1'b1;
    exp_q.push_back(mk(32'h0));
    exp_q.push_back(mk(32'h200));
    exp_q.push_back(mk(32'h204));
    wait_fire(2, "t4a_fetch4");
    @(negedge clk);
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    #2;
    chk("t4a_rsp_same_cycle", 32'(bus.imem_rsp_valid), 32'd1);
    @(negedge clk);
    redirect_valid = 1'b0;
    wait_fire(3, "t4a_target");
    chk("t4a_target_addr", last_fire_addr, 32'h200);
    drain(3, "t4a");

    // Redirect blocks a request in S_REQ, then a redirect right after a handshake.
    do_reset(2);
    bus.id_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h300;
    exp_q.push_back(mk(32'h400));
    exp_q.push_back(mk(32'h404));
    #2;
    chk("t4b_req_suppressed", 32'(bus.imem_req_valid), 32'd0);
    @(negedge clk);
    redirect_valid = 1'b0;
    wait_fire(1, "t4b_first");
    chk("t4b_first_addr", last_fire_addr, 32'h300);
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 32'h400;
    @(negedge clk);
    redirect_valid = 1'b0;
    wait_fire(2, "t4b_target");
    chk("t4b_target_addr", last_fire_addr, 32'h400);
    drain(2, "t4b");

    // PC wrap at the top of the address space.
    do_reset(1);
    bus.id_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    exp_q.push_back(mk(32'hFFFF_FFFC));
    exp_q.push_back(mk(32'h0));
    exp_q.push_back(mk(32'h4));
    @(negedge clk);
    redirect_valid = 1'b0;
    wait_fire(2, "t5_wrap");
    chk("t5_wrap_addr", last_fire_addr, 32'h0);
    drain(3, "t5");

    // Misaligned redirect target.
    do_reset(1);
    bus.id_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h102;
`ifdef FETCH_MISALIGN_CHK_EN
    exp_q.push_back(mkfault(32'h102));
    @(negedge clk);
    redirect_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2;
    chk("t6_no_fetch", 32'(fire_cnt), 32'd0);
    chk("t6_req_halted", 32'(bus.imem_req_valid), 32'd0);
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    exp_q.push_back(mk(32'h200));
    exp_q.push_back(mk(32'h204));
    @(negedge clk);
    redirect_valid = 1'b0;
    drain(3, "t6");
`else
    exp_q.push_back(mk(32'h100));
    exp_q.push_back(mk(32'h104));
    @(negedge clk);
    redirect_valid = 1'b0;
    wait_fire(1, "t6_aligned");
    chk("t6_aligned_addr", last_fire_addr, 32'h100);
    drain(2, "t6");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
